// File: rtl/axi_lite_mem_arbiter_if.sv
// AXI-Lite memory bus bundle. NumPorts > 1 packs several ports side by side,
// with slice i of every field belonging to port i.
interface axi_lite_mem_arbiter_if #(
  parameter int unsigned NumPorts = 1,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned RESP_W   = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [NumPorts*ADDR_W-1:0] readAddr_addr;
  logic [NumPorts-1:0]        readAddr_valid;
  logic [NumPorts-1:0]        readAddr_ready;
  logic [NumPorts*DATA_W-1:0] readData_data;
  logic [NumPorts-1:0]        readData_valid;
  logic [NumPorts-1:0]        readData_ready;
  logic [NumPorts*ADDR_W-1:0] writeAddr_addr;
  logic [NumPorts-1:0]        writeAddr_valid;
  logic [NumPorts-1:0]        writeAddr_ready;
  logic [NumPorts*DATA_W-1:0] writeData_data;
  logic [NumPorts*STRB_W-1:0] writeData_strb;
  logic [NumPorts-1:0]        writeData_valid;
  logic [NumPorts-1:0]        writeData_ready;
  logic [NumPorts*RESP_W-1:0] writeResp_msg;
  logic [NumPorts-1:0]        writeResp_valid;
  logic [NumPorts-1:0]        writeResp_ready;

  modport master (
    output readAddr_addr, readAddr_valid, readData_ready,
    output writeAddr_addr, writeAddr_valid,
    output writeData_data, writeData_strb, writeData_valid, writeResp_ready,
    input  readAddr_ready, readData_data, readData_valid,
    input  writeAddr_ready, writeData_ready, writeResp_msg, writeResp_valid
  );

  modport slave (
    input  readAddr_addr, readAddr_valid, readData_ready,
    input  writeAddr_addr, writeAddr_valid,
    input  writeData_data, writeData_strb, writeData_valid, writeResp_ready,
    output readAddr_ready, readData_data, readData_valid,
    output writeAddr_ready, writeData_ready, writeResp_msg, writeResp_valid
  );
endinterface

// File: rtl/axi_lite_mem_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite memory port between the instruction
// cache (slice 0) and data cache (slice 1); one transaction in flight at a time.
module axi_lite_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned RESP_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_lite_mem_arbiter_if.slave  m,
  axi_lite_mem_arbiter_if.master s,
  output logic [1:0]             grant
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StWrReq, StWrResp} state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] lastGrant_q, lastGrant_d;
  logic       awDone_q, awDone_d;
  logic       wDone_q, wDone_d;
  logic [1:0] req, pick;
  logic       gIdx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      grant_q     <= 2'b00;
      lastGrant_q <= 2'b10;  // M1 counts as last served so M0 wins the first tie
      awDone_q    <= 1'b0;
      wDone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      awDone_q    <= awDone_d;
      wDone_q     <= wDone_d;
    end
  end

  assign gIdx  = grant_q[1];
  assign req   = m.readAddr_valid | m.writeAddr_valid;
  assign pick  = (req == 2'b11) ? ~lastGrant_q : req;
  assign grant = grant_q;

  assign s.readAddr_addr  = gIdx ? m.readAddr_addr[ADDR_W +: ADDR_W]
                                 : m.readAddr_addr[0 +: ADDR_W];
  assign s.writeAddr_addr = gIdx ? m.writeAddr_addr[ADDR_W +: ADDR_W]
                                 : m.writeAddr_addr[0 +: ADDR_W];
  assign s.writeData_data = gIdx ? m.writeData_data[DATA_W +: DATA_W]
                                 : m.writeData_data[0 +: DATA_W];
  assign s.writeData_strb = gIdx ? m.writeData_strb[STRB_W +: STRB_W]
                                 : m.writeData_strb[0 +: STRB_W];
  assign m.readData_data  = {2{s.readData_data}};
  assign m.writeResp_msg  = {2{s.writeResp_msg}};

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    awDone_d    = awDone_q;
    wDone_d     = wDone_q;

    m.readAddr_ready  = 2'b00;
    m.readData_valid  = 2'b00;
    m.writeAddr_ready = 2'b00;
    m.writeData_ready = 2'b00;
    m.writeResp_valid = 2'b00;
    s.readAddr_valid  = 1'b0;
    s.readData_ready  = 1'b0;
    s.writeAddr_valid = 1'b0;
    s.writeData_valid = 1'b0;
    s.writeResp_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          grant_d = pick;
          state_d = ((m.writeAddr_valid & pick) != 2'b00) ? StWrReq : StRdAddr;
        end
      end
      StRdAddr: begin
        s.readAddr_valid       = m.readAddr_valid[gIdx];
        m.readAddr_ready[gIdx] = s.readAddr_ready;
        if (s.readAddr_valid && s.readAddr_ready) state_d = StRdData;
      end
      StRdData: begin
        m.readData_valid[gIdx] = s.readData_valid;
        s.readData_ready       = m.readData_ready[gIdx];
        if (s.readData_valid && s.readData_ready) begin
          state_d     = StIdle;
          lastGrant_d = grant_q;
          grant_d     = 2'b00;
        end
      end
      StWrReq: begin
        // Each channel is masked once its beat has gone, so the slave never sees a repeat.
        s.writeAddr_valid       = !awDone_q && m.writeAddr_valid[gIdx];
        m.writeAddr_ready[gIdx] = !awDone_q && s.writeAddr_ready;
        s.writeData_valid       = !wDone_q && m.writeData_valid[gIdx];
        m.writeData_ready[gIdx] = !wDone_q && s.writeData_ready;
        awDone_d = awDone_q | (s.writeAddr_valid & s.writeAddr_ready);
        wDone_d  = wDone_q | (s.writeData_valid & s.writeData_ready);
        if (awDone_d && wDone_d) begin
          state_d  = StWrResp;
          awDone_d = 1'b0;
          wDone_d  = 1'b0;
        end
      end
      StWrResp: begin
        m.writeResp_valid[gIdx] = s.writeResp_valid;
        s.writeResp_ready       = m.writeResp_ready[gIdx];
        if (s.writeResp_valid && s.writeResp_ready) begin
          state_d     = StIdle;
          lastGrant_d = grant_q;
          grant_d     = 2'b00;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end
endmodule

// File: doc/axi_lite_mem_arbiter.md
Name: axi_lite_mem_arbiter

Overview:
- Shares one AXI-Lite-4 memory slave port between the instruction-cache master (M0) and the data-cache master (M1) of the CPU.
- Sits between the two cache bus ports and the single external memory interface.
- One transaction (read or write) is in flight at a time.
- Arbitration is round-robin between masters; within a master, a pending write beats a pending read.

Parameters:
ADDR_W  32  address width
DATA_W  128  cache line data width; STRB_W = DATA_W/8
RESP_W  32  write response message width

Ports (m_* are packed [2*W-1:0], slice 0 = M0 inst, slice 1 = M1 data; s_* go to memory):
clk  in  1  clock
rst  in  1  asynchronous active-low reset
m_readAddr_addr  in  2*ADDR_W  read address
m_readAddr_valid / m_readAddr_ready  in/out  2 / 2  read address handshake
m_readData_data  out  2*DATA_W  read data (s_readData_data copied to both slices)
m_readData_valid / m_readData_ready  out/in  2 / 2  read data handshake
m_writeAddr_addr  in  2*ADDR_W  write address
m_writeAddr_valid / m_writeAddr_ready  in/out  2 / 2  write address handshake
m_writeData_data  in  2*DATA_W  write data
m_writeData_strb  in  2*STRB_W  byte strobes
m_writeData_valid / m_writeData_ready  in/out  2 / 2  write data handshake
m_writeResp_msg  out  2*RESP_W  response (copied to both slices)
m_writeResp_valid / m_writeResp_ready  out/in  2 / 2  response handshake
s_readAddr_addr, s_readAddr_valid / s_readAddr_ready  out, out / in  ADDR_W, 1 / 1  read address channel
s_readData_data, s_readData_valid / s_readData_ready  in, in / out  DATA_W, 1 / 1  read data channel
s_writeAddr_addr, s_writeAddr_valid / s_writeAddr_ready  out, out / in  ADDR_W, 1 / 1  write address channel
s_writeData_data, s_writeData_strb, s_writeData_valid / s_writeData_ready  out, out, out / in  DATA_W, STRB_W, 1 / 1  write data channel
s_writeResp_msg, s_writeResp_valid / s_writeResp_ready  in, in / out  RESP_W, 1 / 1  write response channel
grant  out  2  one-hot owner of the current transaction; 0 when idle

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE, grant=0, last_grant=1 (M0 wins the first tie), aw_done=w_done=0.
  - Every s_*_valid, s_*_ready, m_*_valid and m_*_ready is 0 immediately.
  - Reset mid-transaction abandons that transaction; no replay.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Registered state and grant; channel muxing is combinational from them.
- IDLE:
  - Master i requests when its readAddr_valid or writeAddr_valid is high.
  - One requester: grant it. Both: grant ~last_grant.
  - Granted master with writeAddr_valid high goes to WR_REQ, otherwise to RD_ADDR.
  - Latency: s_*Addr_valid rises 1 cycle after the master valid is first sampled in IDLE.
  - No ready is returned to any master while in IDLE.
- RD_ADDR:
  - s_readAddr_* = granted master's signals.
  - m_readAddr_ready[g] = s_readAddr_ready.
  - Handshake moves to RD_DATA.
- RD_DATA:
  - m_readData_valid[g] = s_readData_valid; s_readData_ready = m_readData_ready[g].
  - Handshake moves to IDLE and sets last_grant=g.
- WR_REQ:
  - Address and data channels are forwarded independently.
  - aw_done and w_done set on their own handshakes; each channel's valid/ready is masked once its flag is set.
  - Both channels completing in the same cycle, or in either order, is legal.
  - Move to WR_RESP when both are done (including same cycle); flags clear on exit.
- WR_RESP:
  - m_writeResp_valid[g] = s_writeResp_valid; s_writeResp_ready = m_writeResp_ready[g].
  - Handshake moves to IDLE and sets last_grant=g.
- The non-granted master sees all of its valid/ready outputs at 0; its requests stay pending, never dropped.
- The grant is held until the transaction completes even if the master deasserts valid (protocol violation; no abort).
- Back-to-back transactions: minimum 1 IDLE cycle between them; a continuously requesting master alternates with the other.
- No address decode, no response inspection; s_writeResp_msg is passed through unaltered.

Test Plan:
- M0 read 0x0000_0040 alone, slave ready immediately, data 0xA5..A5 -> s_readAddr_valid at cycle+1; M0 gets the data; m_readData_valid[1] stays 0; grant=01 then 00.
- M0 read and M1 write (addr 0x100, strb 0xFFFF) asserted in the same cycle after reset -> M0 is served first, then M1; the slave sees the write only after the M0 readData handshake.
- M1 write with slave writeData_ready before writeAddr_ready, then in the same cycle -> exactly one beat on each channel; response 0x0 reaches M1 only.
- Both masters requesting reads continuously for 6 transactions -> grants alternate 01,10,01,10,01,10.
- M1 has read and write valid simultaneously -> write is served first, then the read.
- rst pulsed low during RD_DATA with the slave stalling -> all valid/ready outputs drop in the same cycle; grant=00; a new M1 request is granted normally afterward.
